// File: rtl/tl_sram_responder.sv
// tl_sram_responder: TileLink-UL slave terminating the muxed A channel into a
// word-addressed SRAM, returning one D-channel response per accepted request.
// One response is held at a time. A new request can be accepted in the same
// cycle that the held response is consumed, so throughput is one per cycle.
//
// Optional feature macro: TL_SRAM_ADDR_CHECK_EN
//   defined   : addresses outside [BASE_ADDR, BASE_ADDR+DEPTH*4) are denied
//   undefined : no range check; the word index aliases modulo DEPTH
module tl_sram_responder #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_a_valid,
  output logic        io_a_ready,
  input  logic [2:0]  io_a_bits_opcode,
  input  logic        io_a_bits_source,
  input  logic [31:0] io_a_bits_address,
  input  logic [3:0]  io_a_bits_mask,
  input  logic [31:0] io_a_bits_data,
  output logic        io_d_valid,
  input  logic        io_d_ready,
  output logic [2:0]  io_d_bits_opcode,
  output logic        io_d_bits_source,
  output logic        io_d_bits_denied,
  output logic [31:0] io_d_bits_data
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] A_PUT_FULL    = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] A_GET         = 3'd4;
  localparam logic [2:0] D_ACK         = 3'd0;
  localparam logic [2:0] D_ACK_DATA    = 3'd1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Storage is deliberately not reset.
  logic [31:0] r_mem [DEPTH];

  logic [2:0]    r_d_opcode;
  logic          r_d_source;
  logic          r_d_denied;
  logic [31:0]   r_d_data;

  logic          w_a_ready;
  logic          w_a_fire;
  logic [31:0]   w_offset;
  logic [AW-1:0] w_idx;
  logic          w_in_range;
  logic          w_legal;
  logic          w_is_get;
  logic [31:0]   w_rd_word;
  logic [2:0]    w_rsp_opcode;
  logic          w_rsp_denied;
  logic [31:0]   w_rsp_data;
  logic          w_mem_access;
  logic          w_mem_we;
  logic          w_unused_bits;

  // The word index is relative to BASE_ADDR; byte-offset bits are ignored.
  assign w_offset  = io_a_bits_address - BASE_ADDR;
  assign w_idx     = w_offset[AW+1:2];
  assign w_rd_word = r_mem[w_idx];

  // Low byte-offset bits and (when unchecked) the aliased high bits are dropped.
  assign w_unused_bits = ^{w_offset[1:0], w_offset[31:AW+2]};

`ifdef TL_SRAM_ADDR_CHECK_EN
  // A below-base address wraps to a large offset, so one unsigned test covers both ends.
  assign w_in_range = ((w_offset >> (AW + 2)) == 32'd0);
`else
  assign w_in_range = 1'b1;
`endif

  assign w_a_fire   = io_a_valid & w_a_ready;
  assign io_a_ready = w_a_ready;
  assign io_d_valid = (r_state == ST_RESP);

  assign io_d_bits_opcode = r_d_opcode;
  assign io_d_bits_source = r_d_source;
  assign io_d_bits_denied = r_d_denied;
  assign io_d_bits_data   = r_d_data;

  // Opcode decode: only PutFull, PutPartial and Get are legal.
  always_comb begin
    w_legal  = 1'b0;
    w_is_get = 1'b0;
    case (io_a_bits_opcode)
      A_PUT_FULL:    w_legal = 1'b1;
      A_PUT_PARTIAL: w_legal = 1'b1;
      A_GET: begin
        w_legal  = 1'b1;
        w_is_get = 1'b1;
      end
      default: begin
        w_legal  = 1'b0;
        w_is_get = 1'b0;
      end
    endcase
  end

  // Build the response for the request on A and decide whether it touches memory.
  always_comb begin
    w_rsp_opcode = D_ACK;
    w_rsp_denied = 1'b0;
    w_rsp_data   = 32'd0;
    w_mem_access = 1'b0;
    if (!w_legal) begin
      w_rsp_denied = 1'b1;
    end else if (!w_in_range) begin
      w_rsp_denied = 1'b1;
      if (w_is_get) begin
        w_rsp_opcode = D_ACK_DATA;
      end else begin
        w_rsp_opcode = D_ACK;
      end
    end else if (w_is_get) begin
      w_rsp_opcode = D_ACK_DATA;
      w_rsp_data   = w_rd_word;
      w_mem_access = 1'b1;
    end else begin
      w_mem_access = 1'b1;
    end
  end

  // A write is blocked while reset is asserted so no partial transaction lands.
  assign w_mem_we = w_a_fire & w_mem_access & ~w_is_get & ~reset;

  // Next-state and A-ready: a held response must drain before (or as) a new one is accepted.
  always_comb begin
    w_next_state = r_state;
    w_a_ready    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_a_ready = 1'b1;
        if (io_a_valid) begin
          w_next_state = ST_RESP;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_RESP: begin
        w_a_ready = io_d_ready;
        if (io_d_ready & io_a_valid) begin
          w_next_state = ST_RESP;
        end else if (io_d_ready) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_RESP;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_a_ready    = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Response register: loaded on every A fire, otherwise held stable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_d_opcode <= 3'd0;
      r_d_source <= 1'b0;
      r_d_denied <= 1'b0;
      r_d_data   <= 32'd0;
    end else if (w_a_fire) begin
      r_d_opcode <= w_rsp_opcode;
      r_d_source <= io_a_bits_source;
      r_d_denied <= w_rsp_denied;
      r_d_data   <= w_rsp_data;
    end
  end

  // Byte-lane masked SRAM write; both Put opcodes honour the mask.
  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (io_a_bits_mask[b]) begin
          r_mem[w_idx][8*b +: 8] <= io_a_bits_data[8*b +: 8];
        end
      end
    end
  end

endmodule
